// File: rtl/store_drain_buffer.sv
// In-order committed-store buffer in front of a single-port dmem. Loads and
// store drains share the dmem port; a starvation counter forces drains under load pressure.
module store_drain_buffer #(
  parameter int DEPTH      = 4,
  parameter int MATCH_BITS = 6,
  parameter int STARVE_MAX = 8,
  parameter int ADDR_LEN   = 32,
  parameter int DATA_LEN   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_valid,
  input  logic [ADDR_LEN-1:0] push_addr,
  input  logic [DATA_LEN-1:0] push_data,
  output logic                push_ready,
  input  logic                ld_valid,
  input  logic [ADDR_LEN-1:0] ld_addr,
  output logic                ld_ready,
  output logic [DATA_LEN-1:0] ld_data,
  output logic                ld_fwd,
  output logic                sb_empty,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [DATA_LEN-1:0] dmem_wdata,
  output logic                dmem_we,
  input  logic [DATA_LEN-1:0] dmem_rdata
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [ST_W-1:0]  STARVE_TOP = ST_W'(STARVE_MAX);

  logic [ADDR_LEN-1:0] addr_q [DEPTH];
  logic [DATA_LEN-1:0] data_q [DEPTH];
  logic [PTR_W:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ST_W-1:0]     starve_q, starve_d;

  logic [PTR_W-1:0]    head_idx, tail_idx, scan_idx;
  logic                force_drain, drain, push_fire;
  logic                fwd_hit;
  logic [DATA_LEN-1:0] fwd_data;

  assign head_idx    = head_q[PTR_W-1:0];
  assign tail_idx    = tail_q[PTR_W-1:0];
  assign sb_empty    = (head_q == tail_q);
  assign push_ready  = (count_q != FULL_CNT);
  assign push_fire   = push_valid & push_ready;
  assign force_drain = (starve_q == STARVE_TOP) & ~sb_empty;
  // Reset suppresses the write so a discarded store never reaches dmem.
  assign drain       = ~reset & (force_drain | (~ld_valid & ~sb_empty));

  assign ld_ready    = ~force_drain;
  assign dmem_we     = drain;
  assign dmem_addr   = drain ? addr_q[head_idx] : ld_addr;
  assign dmem_wdata  = data_q[head_idx];
  assign ld_fwd      = fwd_hit;
  assign ld_data     = fwd_hit ? fwd_data : dmem_rdata;

  // Scan oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_idx + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (addr_q[scan_idx][MATCH_BITS-1:0] == ld_addr[MATCH_BITS-1:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[scan_idx];
      end
    end
  end

  always_comb begin
    head_d   = head_q + (PTR_W + 1)'(drain);
    tail_d   = tail_q + (PTR_W + 1)'(push_fire);
    count_d  = count_q + CNT_W'(push_fire) - CNT_W'(drain);
    starve_d = starve_q;
    if (sb_empty || drain) begin
      starve_d = '0;
    end else if (ld_valid && (starve_q != STARVE_TOP)) begin
      starve_d = starve_q + ST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      addr_q[tail_idx] <= push_addr;
      data_q[tail_idx] <= push_data;
    end
  end
endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer with a behavioural async-read / sync-write dmem.
module tb_store_drain_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic        push_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_fwd;
  logic        sb_empty;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;

  logic [31:0] mem [64] = '{default: 32'h0};
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (dmem_we) mem[dmem_addr[5:0]] <= dmem_wdata;
  assign dmem_rdata = mem[dmem_addr[5:0]];

  store_drain_buffer dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data), .push_ready(push_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_data(ld_data), .ld_fwd(ld_fwd),
    .sb_empty(sb_empty), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0; push_addr = '0; push_data = '0;
    ld_valid = 1'b0; ld_addr = '0;
  endtask

  task automatic drain_all(input string name);
    int n;
    idle_inputs();
    n = 0;
    while (!sb_empty && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (sb_empty !== 1'b1) begin
      fails++;
      $display("FAIL %s_drain_timeout sb_empty=%b required=1", name, sb_empty);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    tests++; if (push_ready !== 1'b1) begin fails++; $display("FAIL rst_push_ready got=%b exp=1", push_ready); end
    tests++; if (sb_empty !== 1'b1) begin fails++; $display("FAIL rst_sb_empty got=%b exp=1", sb_empty); end
    tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL rst_ld_ready got=%b exp=1", ld_ready); end
    tests++; if (dmem_we !== 1'b0) begin fails++; $display("FAIL rst_dmem_we got=%b exp=0", dmem_we); end
    tests++; if (ld_fwd !== 1'b0) begin fails++; $display("FAIL rst_ld_fwd got=%b exp=0", ld_fwd); end
  endtask

  task automatic test_single_drain();
    push_valid = 1'b1; push_addr = 32'd5; push_data = 32'hA5A5A5A5;
    step();
    idle_inputs();
    #1;
    tests++; if (dmem_we !== 1'b1) begin fails++; $display("FAIL single_we got=%b exp=1", dmem_we); end
    tests++; if (dmem_addr !== 32'd5) begin fails++; $display("FAIL single_addr got=%h exp=5", dmem_addr); end
    tests++; if (dmem_wdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL single_wdata got=%h exp=a5a5a5a5", dmem_wdata); end
    step();
    tests++; if (sb_empty !== 1'b1) begin fails++; $display("FAIL single_empty got=%b exp=1", sb_empty); end
    tests++; if (dmem_we !== 1'b0) begin fails++; $display("FAIL single_we_after got=%b exp=0", dmem_we); end
    tests++; if (mem[5] !== 32'hA5A5A5A5) begin fails++; $display("FAIL single_mem got=%h exp=a5a5a5a5", mem[5]); end
  endtask

  task automatic test_fill_starve();
    ld_valid = 1'b1; ld_addr = 32'd40;
    for (int c = 0; c < 4; c++) begin
      push_valid = 1'b1; push_addr = 32'(c + 1); push_data = 32'h100 + 32'(c + 1);
      #1;
      tests++; if (push_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_c%0d got=%b exp=1", c, push_ready); end
      if (c > 0) begin
        tests++; if (dmem_we !== 1'b0) begin fails++; $display("FAIL fill_we_c%0d got=%b exp=0", c, dmem_we); end
      end
      step();
    end
    push_valid = 1'b1; push_addr = 32'd9; push_data = 32'hBAD;
    #1;
    tests++; if (push_ready !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", push_ready); end
    tests++; if (ld_fwd !== 1'b0) begin fails++; $display("FAIL full_nomatch_fwd got=%b exp=0", ld_fwd); end
    step();
    push_valid = 1'b0;
    for (int c = 5; c < 9; c++) begin
      #1;
      tests++; if (dmem_we !== 1'b0 || ld_ready !== 1'b1) begin fails++; $display("FAIL blocked_c%0d we=%b ld_ready=%b exp we=0 ld_ready=1", c, dmem_we, ld_ready); end
      step();
    end
    tests++; if (dmem_we !== 1'b1) begin fails++; $display("FAIL force_we got=%b exp=1", dmem_we); end
    tests++; if (dmem_addr !== 32'd1) begin fails++; $display("FAIL force_addr got=%h exp=1", dmem_addr); end
    tests++; if (ld_ready !== 1'b0) begin fails++; $display("FAIL force_ld_ready got=%b exp=0", ld_ready); end
    step();
    tests++; if (push_ready !== 1'b1 || ld_ready !== 1'b1) begin fails++; $display("FAIL post_force push_ready=%b ld_ready=%b exp 1 1", push_ready, ld_ready); end
    drain_all("fill");
    for (int a = 1; a <= 4; a++) begin
      tests++; if (mem[a] !== 32'h100 + 32'(a)) begin fails++; $display("FAIL fill_mem%0d got=%h exp=%h", a, mem[a], 32'h100 + 32'(a)); end
    end
    tests++; if (mem[9] !== 32'h0) begin fails++; $display("FAIL refused_push_mem9 got=%h exp=0", mem[9]); end
  endtask

  task automatic test_same_addr_forward();
    ld_valid = 1'b1; ld_addr = 32'd7;
    push_valid = 1'b1; push_addr = 32'd7; push_data = 32'd1;
    #1;
    tests++; if (ld_fwd !== 1'b0) begin fails++; $display("FAIL same_cycle_fwd got=%b exp=0", ld_fwd); end
    step();
    push_data = 32'd2;
    #1;
    tests++; if (ld_fwd !== 1'b1 || ld_data !== 32'd1) begin fails++; $display("FAIL fwd_first fwd=%b data=%h exp 1 1", ld_fwd, ld_data); end
    step();
    push_valid = 1'b0;
    #1;
    tests++; if (ld_fwd !== 1'b1 || ld_data !== 32'd2) begin fails++; $display("FAIL fwd_youngest fwd=%b data=%h exp 1 2", ld_fwd, ld_data); end
    drain_all("same_addr");
    tests++; if (mem[7] !== 32'd2) begin fails++; $display("FAIL same_addr_mem7 got=%h exp=2", mem[7]); end
    ld_valid = 1'b1; ld_addr = 32'd7;
    #1;
    tests++; if (ld_fwd !== 1'b0 || ld_data !== 32'd2) begin fails++; $display("FAIL dmem_read fwd=%b data=%h exp 0 2", ld_fwd, ld_data); end
  endtask

  task automatic test_aliasing();
    ld_valid = 1'b1; ld_addr = 32'd8;
    push_valid = 1'b1; push_addr = 32'h47; push_data = 32'hDEAD;
    step();
    push_valid = 1'b0;
    ld_addr = 32'h07;
    #1;
    tests++; if (ld_fwd !== 1'b1 || ld_data !== 32'hDEAD) begin fails++; $display("FAIL alias_fwd fwd=%b data=%h exp 1 dead", ld_fwd, ld_data); end
    ld_addr = 32'h08;
    #1;
    tests++; if (ld_fwd !== 1'b0) begin fails++; $display("FAIL alias_nomatch fwd=%b exp=0", ld_fwd); end
    drain_all("alias");
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] exp_a;
    ld_valid = 1'b1; ld_addr = 32'd60;
    for (int c = 0; c < 3; c++) begin
      push_valid = 1'b1; push_addr = 32'h20 + 32'(c); push_data = 32'h200 + 32'(c);
      q.push_back(32'h20 + 32'(c));
      step();
    end
    ld_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      push_valid = 1'b1; push_addr = 32'h10 + 32'(k); push_data = 32'h300 + 32'(k);
      #1;
      exp_a = q.pop_front();
      tests++; if (push_ready !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== exp_a) begin
        fails++; $display("FAIL b2b_k%0d ready=%b we=%b addr=%h exp 1 1 %h", k, push_ready, dmem_we, dmem_addr, exp_a);
      end
      q.push_back(32'h10 + 32'(k));
      step();
    end
    push_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_a = q.pop_front();
      tests++; if (dmem_we !== 1'b1 || dmem_addr !== exp_a) begin
        fails++; $display("FAIL b2b_tail%0d we=%b addr=%h exp 1 %h", k, dmem_we, dmem_addr, exp_a);
      end
      step();
    end
    tests++; if (sb_empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got=%b exp=1", sb_empty); end
    tests++; if (mem[6'h19] !== 32'h309) begin fails++; $display("FAIL b2b_mem19 got=%h exp=309", mem[6'h19]); end
  endtask

  task automatic test_reset_midop();
    ld_valid = 1'b1; ld_addr = 32'd61;
    for (int c = 0; c < 3; c++) begin
      push_valid = 1'b1; push_addr = 32'h30 + 32'(c); push_data = 32'h400 + 32'(c);
      step();
    end
    idle_inputs();
    reset = 1'b1;
    #1;
    tests++; if (dmem_we !== 1'b0) begin fails++; $display("FAIL midrst_we_in_reset got=%b exp=0", dmem_we); end
    step();
    reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h30;
    #1;
    tests++; if (sb_empty !== 1'b1) begin fails++; $display("FAIL midrst_empty got=%b exp=1", sb_empty); end
    tests++; if (dmem_we !== 1'b0) begin fails++; $display("FAIL midrst_we got=%b exp=0", dmem_we); end
    tests++; if (ld_fwd !== 1'b0) begin fails++; $display("FAIL midrst_fwd got=%b exp=0", ld_fwd); end
    tests++; if (mem[6'h30] !== 32'h0) begin fails++; $display("FAIL midrst_mem30 got=%h exp=0", mem[6'h30]); end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_drain();
    test_fill_starve();
    test_same_addr_forward();
    test_aliasing();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
